// File: rtl/timer_cmp_if.sv
// Peripheral bus bundle for timer_cmp: select/write/address/data in,
// OR-bus read data and level interrupt out.
interface timer_cmp_if;
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] di;
    logic [31:0] dout;
    logic        irq;

    modport master (output cs, we, addr, di, input dout, irq);
    modport slave  (input cs, we, addr, di, output dout, irq);
endinterface

// File: rtl/timer_cmp.sv
// Memory-mapped system timer: prescaled counter, NCMP compare channels,
// optional periodic reload on CMP0, overflow flag and level interrupt.
module timer_cmp #(
    parameter int CLK_DIV = 12,
    parameter int WIDTH   = 32,
    parameter int NCMP    = 2
) (
    input logic        clk,
    input logic        rst,
    timer_cmp_if.slave bus
);
    localparam int              DW       = $clog2(CLK_DIV) + 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] count_reg;
    logic [DW-1:0]    div_reg;
    logic             en_reg;
    logic             periodic_reg;
    logic [NCMP-1:0]  mf_reg;
    logic [NCMP-1:0]  mf_ien_reg;
    logic             ovf_reg;
    logic             ovf_ien_reg;
    logic [WIDTH-1:0] cmp_reg [NCMP];
    logic             oe_reg;
    logic [31:0]      rdata_reg;

    logic            wr;
    logic            rd;
    logic            tick;
    logic            count_wr;
    logic            status_wr;
    logic            ien_wr;
    logic            ctrl_wr;
    logic            count_tick;
    logic            wrap_period;
    logic            wrap_max;
    logic            ovf_set;
    logic            ovf_clr;
    logic [NCMP-1:0] match;
    logic [NCMP-1:0] mf_set;
    logic [NCMP-1:0] mf_clr;
    logic [31:0]     status_word;
    logic [31:0]     ien_word;
    logic [31:0]     rd_mux;
    logic            unused_di;

    assign wr        = bus.cs && bus.we;
    assign rd        = bus.cs && !bus.we;
    assign count_wr  = wr && (bus.addr == 4'd0);
    assign ctrl_wr   = wr && (bus.addr == 4'd1);
    assign status_wr = wr && (bus.addr == 4'd2);
    assign ien_wr    = wr && (bus.addr == 4'd3);
    assign tick      = en_reg && (div_reg == DIV_LAST);
    // A COUNT write on a tick edge suppresses both the increment and its flags.
    assign count_tick = tick && !count_wr;

    generate
        for (genvar gi = 0; gi < NCMP; gi++) begin : g_ch
            assign match[gi]  = (count_reg == cmp_reg[gi]);
            assign mf_set[gi] = count_tick && match[gi];
            assign mf_clr[gi] = status_wr && bus.di[gi];
        end
    endgenerate

    assign wrap_period = periodic_reg && match[0];
    assign wrap_max    = !wrap_period && (count_reg == CNT_MAX);
    assign ovf_set     = count_tick && wrap_max;
    assign ovf_clr     = status_wr && bus.di[15];
    assign unused_di   = &{1'b0, bus.di};

    always_comb begin
        status_word           = '0;
        status_word[NCMP-1:0] = mf_reg;
        status_word[15]       = ovf_reg;
        ien_word              = '0;
        ien_word[NCMP-1:0]    = mf_ien_reg;
        ien_word[15]          = ovf_ien_reg;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            4'd0:    rd_mux = 32'(count_reg);
            4'd1:    rd_mux = {30'b0, periodic_reg, en_reg};
            4'd2:    rd_mux = status_word;
            4'd3:    rd_mux = ien_word;
            default: begin
                for (int k = 0; k < NCMP; k++) begin
                    if (bus.addr == 4'(4 + k)) rd_mux = 32'(cmp_reg[k]);
                end
            end
        endcase
    end

    // Prescaler and counter; both hold while EN is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            div_reg   <= '0;
        end else if (count_wr) begin
            count_reg <= bus.di[WIDTH-1:0];
            div_reg   <= '0;
        end else if (en_reg) begin
            div_reg <= tick ? '0 : div_reg + 1'b1;
            if (tick) count_reg <= (wrap_period || wrap_max) ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_reg       <= 1'b1;
            periodic_reg <= 1'b0;
            mf_reg       <= '0;
            ovf_reg      <= 1'b0;
            mf_ien_reg   <= '0;
            ovf_ien_reg  <= 1'b0;
            oe_reg       <= 1'b0;
            rdata_reg    <= '0;
            for (int k = 0; k < NCMP; k++) cmp_reg[k] <= '1;
        end else begin
            if (ctrl_wr) begin
                en_reg       <= bus.di[0];
                periodic_reg <= bus.di[1];
            end
            // Set events beat a same-cycle write-one-to-clear.
            mf_reg  <= (mf_reg & ~mf_clr) | mf_set;
            ovf_reg <= (ovf_reg && !ovf_clr) || ovf_set;
            if (ien_wr) begin
                mf_ien_reg  <= bus.di[NCMP-1:0];
                ovf_ien_reg <= bus.di[15];
            end
            for (int k = 0; k < NCMP; k++) begin
                if (wr && (bus.addr == 4'(4 + k))) cmp_reg[k] <= bus.di[WIDTH-1:0];
            end
            oe_reg <= rd;
            if (rd) rdata_reg <= rd_mux;
        end
    end

    assign bus.dout = oe_reg ? rdata_reg : '0;
    assign bus.irq  = (|(mf_reg & mf_ien_reg)) | (ovf_reg & ovf_ien_reg);
endmodule

// File: tb/tb_timer_cmp.sv
// Directed bench for timer_cmp (CLK_DIV=4, WIDTH=8, NCMP=2) with a
// cycle-level register model checked every cycle plus literal expectations.
module tb_timer_cmp;
    localparam int          CLK_DIV = 4;
    localparam logic [31:0] MAXC    = 32'hFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    timer_cmp_if bus();

    timer_cmp #(.CLK_DIV(CLK_DIV), .WIDTH(8), .NCMP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Register-level model: what a programmer would expect from the map.
    logic [31:0] m_count, m_status, m_ien, m_rdata;
    logic [31:0] m_cmp [2];
    int          m_phase;
    bit          m_en, m_per, m_oe;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_count = 0; m_phase = 0; m_en = 1; m_per = 0;
        m_status = 0; m_ien = 0; m_cmp[0] = MAXC; m_cmp[1] = MAXC;
        m_oe = 0; m_rdata = 0;
    endtask

    function automatic logic [31:0] m_reg(input logic [3:0] a);
        case (a)
            4'd0:    return m_count;
            4'd1:    return {30'b0, m_per, m_en};
            4'd2:    return m_status;
            4'd3:    return m_ien;
            4'd4:    return m_cmp[0];
            4'd5:    return m_cmp[1];
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_step(input logic c, input logic w, input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rv  = m_reg(a);
        logic [31:0] set = 0;
        bit tick = m_en && (m_phase == CLK_DIV - 1);
        bit wr   = c && w;
        if (wr && a == 0) begin
            m_count = d & MAXC;
            m_phase = 0;
        end else if (m_en) begin
            m_phase = (m_phase + 1) % CLK_DIV;
            if (tick) begin
                for (int k = 0; k < 2; k++) if (m_count == m_cmp[k]) set[k] = 1'b1;
                if (m_per && m_count == m_cmp[0]) m_count = 0;
                else if (m_count == MAXC) begin m_count = 0; set[15] = 1'b1; end
                else m_count = m_count + 1;
            end
        end
        if (wr && a == 2) m_status = m_status & ~d;
        m_status = m_status | set;
        if (wr && a == 1) begin m_en = d[0]; m_per = d[1]; end
        if (wr && a == 3) m_ien = d & 32'h8003;
        if (wr && a == 4) m_cmp[0] = d & MAXC;
        if (wr && a == 5) m_cmp[1] = d & MAXC;
        m_oe = c && !w;
        if (m_oe) m_rdata = rv;
    endtask

    // Compare process: step the model on each edge, check outputs mid-cycle.
    initial begin
        m_reset();
        forever begin
            @(posedge clk);
            if (rst) m_reset();
            else m_step(bus.cs, bus.we, bus.addr, bus.di);
            @(negedge clk);
            chk("model_do", bus.dout, m_oe ? m_rdata : 32'h0);
            chk("model_irq", {31'b0, bus.irq}, {31'b0, |(m_status & m_ien)});
        end
    end

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        bus.cs = 1; bus.we = 1; bus.addr = a; bus.di = d;
        @(negedge clk);
        bus.cs = 0; bus.we = 0;
        $display("wr addr=%0d data=%h", a, d);
    endtask

    task automatic bus_rd(input logic [3:0] a, input logic [31:0] exp, input string name);
        bus.cs = 1; bus.we = 0; bus.addr = a;
        @(negedge clk);
        bus.cs = 0;
        $display("rd addr=%0d data=%h", a, bus.dout);
        chk(name, bus.dout, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.cs = 0; bus.we = 0; bus.addr = 0; bus.di = 0;
        idle(2);
        chk("rst_do", bus.dout, 32'h0);
        chk("rst_irq", {31'b0, bus.irq}, 32'h0);
        rst = 0;

        // Free-run: reset values, then COUNT=10 read on edge 41.
        bus_rd(1, 32'h1, "rst_ctrl");
        bus_rd(4, 32'hFF, "rst_cmp0");
        bus_rd(5, 32'hFF, "rst_cmp1");
        bus_rd(2, 32'h0, "rst_status");
        bus_rd(0, 32'd1, "count_edge5");
        idle(35);
        bus_rd(0, 32'd10, "count_edge41");

        // Periodic with CMP0=4; MF0 set on the 4->0 tick 20 edges after the load.
        bus_wr(4, 4);
        bus_wr(0, 0);
        bus_wr(1, 3);
        bus_wr(3, 1);
        idle(17);
        chk("irq_before_wrap", {31'b0, bus.irq}, 32'h0);
        idle(1);
        chk("irq_after_wrap", {31'b0, bus.irq}, 32'h1);
        bus_rd(2, 32'h1, "status_mf0");
        bus_rd(0, 32'd0, "count_wrapped");
        bus_wr(2, 1);
        chk("irq_w1c", {31'b0, bus.irq}, 32'h0);
        idle(16);
        bus_wr(2, 1);
        chk("irq_w1c_collide", {31'b0, bus.irq}, 32'h1);
        bus_wr(2, 1);
        chk("irq_cleared", {31'b0, bus.irq}, 32'h0);

        // Overflow from 0xFE, with CMP1=0xFF matching the wrapping tick.
        bus_wr(1, 1);
        bus_wr(5, 32'hFFFF_FFFF);
        bus_wr(0, 32'h1234_56FE);
        idle(7);
        bus_rd(0, 32'hFF, "count_ff");
        bus_rd(0, 32'h0, "count_ovf_wrap");
        bus_rd(2, 32'h8002, "status_ovf_mf1");
        bus_wr(3, 32'h8000);
        chk("irq_ien_pending", {31'b0, bus.irq}, 32'h1);
        bus_wr(2, 32'hFFFF_FFFF);
        chk("irq_ovf_cleared", {31'b0, bus.irq}, 32'h0);

        // COUNT write on a tick edge wins and restarts the prescaler.
        idle(3);
        bus_wr(0, 100);
        bus_rd(0, 32'd100, "collide_load");
        idle(2);
        bus_rd(0, 32'd100, "collide_pretick");
        bus_rd(0, 32'd101, "collide_next");

        // Enable gating: frozen for 20+ cycles, partial prescale preserved.
        bus_wr(1, 0);
        idle(20);
        bus_rd(0, 32'd101, "frozen_count");
        bus_wr(1, 1);
        bus_rd(0, 32'd101, "resume_1");
        bus_rd(0, 32'd101, "resume_2");
        bus_rd(0, 32'd102, "resume_tick");

        // Unmapped and absent-channel indices.
        bus_rd(12, 32'h0, "unmapped_12");
        bus_wr(6, 123);
        bus_rd(6, 32'h0, "unmapped_6");
        bus_rd(4, 32'd4, "cmp0_value");
        bus_rd(3, 32'h8000, "irqen_value");

        // Async reset between edges with irq high and do driving.
        bus_wr(3, 2);
        bus_wr(0, 32);
        bus_wr(5, 32);
        idle(4);
        chk("irq_mf1", {31'b0, bus.irq}, 32'h1);
        bus_rd(0, 32'd33, "count_before_rst");
        #2 rst = 1;
        #1;
        chk("async_do", bus.dout, 32'h0);
        chk("async_irq", {31'b0, bus.irq}, 32'h0);
        idle(2);
        rst = 0;
        bus_rd(0, 32'h0, "count_after_rst");
        bus_rd(2, 32'h0, "status_after_rst");
        bus_rd(1, 32'h1, "ctrl_after_rst");

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
